// File: rtl/rc_multicast_fork_pkg.sv
// Shared constants for the multicast route-compute fork: direction encodings,
// destination-field placement and the flit rewrite helper.
package rc_mc_pkg;

  typedef logic [4:0] dir_t;

  localparam dir_t DIR_L = 5'b00001;
  localparam dir_t DIR_S = 5'b00010;
  localparam dir_t DIR_E = 5'b00100;
  localparam dir_t DIR_W = 5'b01000;
  localparam dir_t DIR_N = 5'b10000;

  localparam int RC_DST_LSB = 9;
  localparam int RC_DST_W   = 16;

  // Widest flit the helper handles; callers zero-extend in and truncate out.
  localparam int FLIT_MAX = 64;

  // Replace the bits under `field` with `sub_pos` and mark the copy in bit 0.
  function automatic logic [FLIT_MAX-1:0] rewrite_dst(input logic [FLIT_MAX-1:0] flit,
                                                      input logic [FLIT_MAX-1:0] field,
                                                      input logic [FLIT_MAX-1:0] sub_pos);
    return (flit & ~field) | (sub_pos & field) | {{(FLIT_MAX-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rc_multicast_fork_if.sv
// Input flit handshake plus the per-port copy channels of the multicast fork.
interface rc_multicast_fork_if #(
  parameter int DATASIZE = 30,
  parameter int NUM_OUT  = 3
) ();
  logic [DATASIZE-1:0]               in_data;
  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_OUT-1:0][DATASIZE-1:0]  out_data;
  logic [NUM_OUT-1:0][4:0]           out_dir;
  logic [NUM_OUT-1:0]                out_valid;
  logic [NUM_OUT-1:0]                out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_dir, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_dir, out_valid
  );
endinterface

// File: rtl/rc_mc_out_slot.sv
// One-deep valid/ready holding register for a single output copy.
module rc_mc_out_slot
  import rc_mc_pkg::*;
#(
  parameter int DW = 30
) (
  input  logic          rc_clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  dir_t          load_dir,
  input  logic          out_ready,
  output logic          free,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output dir_t          out_dir
);

  assign free = ~out_valid | out_ready;

  // Load wins over drain so a draining slot refills with no bubble.
  always_ff @(posedge rc_clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dir   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_dir   <= load_dir;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_dir   <= '0;
    end
  end

endmodule

// File: rtl/rc_multicast_fork.sv
// Multicast route compute: splits the destination bitmap of each flit across
// NUM_OUT ports and loads one copy per port with a non-empty sub-bitmap.
module rc_multicast_fork
  import rc_mc_pkg::*;
#(
  parameter int                         DATASIZE  = 30,
  parameter int                         DST_W     = RC_DST_W,
  parameter int                         DST_LSB   = RC_DST_LSB,
  parameter int                         NUM_OUT   = 3,
  parameter logic [NUM_OUT*DST_W-1:0]   PORT_MASK = {16'h000F, 16'h0010, 16'hFF00},
  parameter logic [NUM_OUT*5-1:0]       PORT_DIR  = {DIR_S, DIR_L, DIR_E},
  parameter int                         CNT_W     = 16
) (
  input  logic             rc_clk,
  input  logic             rst,
  rc_multicast_fork_if.slave bus,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [DATASIZE-1:0] FIELD = DATASIZE'({DST_W{1'b1}}) << DST_LSB;

  logic [DST_W-1:0]                 dst;
  logic [NUM_OUT-1:0]               need, free, valid_q;
  logic [NUM_OUT-1:0][DATASIZE-1:0] load_data, data_q;
  dir_t [NUM_OUT-1:0]               dir_q;
  logic                             in_ready, accept;

  assign dst = bus.in_data[DST_LSB +: DST_W];

  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_port
      logic [DST_W-1:0] sub;

      assign sub          = dst & PORT_MASK[i*DST_W +: DST_W];
      assign need[i]      = |sub;
      assign load_data[i] = DATASIZE'(rewrite_dst(FLIT_MAX'(bus.in_data), FLIT_MAX'(FIELD),
                                                  FLIT_MAX'(sub) << DST_LSB));

      rc_mc_out_slot #(.DW(DATASIZE)) u_slot (
        .rc_clk    (rc_clk),
        .rst       (rst),
        .load      (accept & need[i]),
        .load_data (load_data[i]),
        .load_dir  (PORT_DIR[i*5 +: 5]),
        .out_ready (bus.out_ready[i]),
        .free      (free[i]),
        .out_valid (valid_q[i]),
        .out_data  (data_q[i]),
        .out_dir   (dir_q[i])
      );
    end
  endgenerate

  // All slots must be free so every copy of a flit lands in the same cycle.
  assign in_ready      = ~rst & (&free);
  assign accept        = bus.in_valid & in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_dir   = dir_q;

  always_ff @(posedge rc_clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && !(|need) && drop_cnt != {CNT_W{1'b1}}) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rc_multicast_fork.sv
// Directed bench for rc_multicast_fork: vector table plus hand-written
// reset, backpressure, drop-saturation and reset-mid-stall sequences.
module tb_rc_multicast_fork;

  localparam int DW = 30;
  localparam int NO = 3;

  logic        rc_clk = 1'b0;
  logic        rst;
  logic [15:0] drop_cnt;
  logic [2:0]  sat_cnt;
  int          errors = 0;
  int          checks = 0;

  always #5 rc_clk = ~rc_clk;

  rc_multicast_fork_if #(.DATASIZE(DW), .NUM_OUT(NO)) bus ();
  rc_multicast_fork_if #(.DATASIZE(DW), .NUM_OUT(NO)) sbus ();

  rc_multicast_fork dut (
    .rc_clk   (rc_clk),
    .rst      (rst),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  // Narrow-counter copy fed the same stimulus, to reach saturation quickly.
  rc_multicast_fork #(.CNT_W(3)) dut_sat (
    .rc_clk   (rc_clk),
    .rst      (rst),
    .bus      (sbus),
    .drop_cnt (sat_cnt)
  );

  assign sbus.in_data   = bus.in_data;
  assign sbus.in_valid  = bus.in_valid;
  assign sbus.out_ready = bus.out_ready;

  typedef struct {
    logic        vld;
    logic [15:0] dst;
    logic [2:0]  ev;
    logic [15:0] e0, e1, e2;
    logic [15:0] edrop;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [29:0] mk(input logic [15:0] d, input int k);
    return {5'(k + 3), d, 9'(k * 6 + 2)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic [2:0] ev,
                            input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                            input int k, input logic [15:0] edrop);
    logic [15:0] e   [3];
    logic [4:0]  dir [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    dir[0] = 5'b00100; dir[1] = 5'b00001; dir[2] = 5'b00010;
    chk({nm, " valid"}, 64'(bus.out_valid), 64'(ev));
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("%s dir%0d", nm, p), 64'(bus.out_dir[p]), 64'(ev[p] ? dir[p] : 5'b0));
      if (ev[p])
        chk($sformatf("%s data%0d", nm, p), 64'(bus.out_data[p]),
            64'({5'(k + 3), e[p], 9'(k * 6 + 3)}));
    end
    chk({nm, " drop"}, 64'(drop_cnt), 64'(edrop));
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h8113, 3'b111, 16'h8100, 16'h0010, 16'h0003, 16'd0};
    vecs[1] = '{1'b1, 16'h0002, 3'b100, 16'h0000, 16'h0000, 16'h0002, 16'd0};
    vecs[2] = '{1'b1, 16'h0200, 3'b001, 16'h0200, 16'h0000, 16'h0000, 16'd0};
    vecs[3] = '{1'b1, 16'h00E0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'd1};
    vecs[4] = '{1'b1, 16'h00E0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'd2};
    vecs[5] = '{1'b1, 16'h00E0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'd3};
    vecs[6] = '{1'b1, 16'h0011, 3'b110, 16'h0000, 16'h0010, 16'h0001, 16'd3};
    vecs[7] = '{1'b0, 16'h8113, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'd3};
    vecs[8] = '{1'b1, 16'hFFFF, 3'b111, 16'hFF00, 16'h0010, 16'h000F, 16'd3};

    // Reset held two cycles with a flit offered.
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = mk(16'h8113, 0);
    bus.out_ready = 3'b111;
    repeat (2) begin
      @(posedge rc_clk); #1;
      chk("rst in_ready", 64'(bus.in_ready), 64'(0));
      chk("rst valid", 64'(bus.out_valid), 64'(0));
      chk("rst dir", 64'(bus.out_dir), 64'(0));
      chk("rst data", 64'(bus.out_data), 64'(0));
      chk("rst drop", 64'(drop_cnt), 64'(0));
    end
    @(negedge rc_clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    // Table: one vector per cycle, all ports ready, back-to-back.
    for (int i = 0; i < 9; i++) begin
      @(negedge rc_clk);
      bus.in_valid  = vecs[i].vld;
      bus.in_data   = mk(vecs[i].dst, i);
      bus.out_ready = 3'b111;
      #1 chk($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'(1));
      @(posedge rc_clk); #1;
      check_outs($sformatf("v%0d", i), vecs[i].ev, vecs[i].e0, vecs[i].e1, vecs[i].e2,
                 i, vecs[i].edrop);
    end

    // Idle cycle drains everything.
    @(negedge rc_clk);
    bus.in_valid = 1'b0;
    @(posedge rc_clk); #1;
    chk("idle valid", 64'(bus.out_valid), 64'(0));

    // Backpressure on port 1.
    @(negedge rc_clk);
    bus.out_ready = 3'b101;
    bus.in_valid  = 1'b1;
    bus.in_data   = mk(16'h0010, 20);
    @(posedge rc_clk); #1;
    check_outs("bp load", 3'b010, 16'h0, 16'h0010, 16'h0, 20, 16'd3);
    @(negedge rc_clk);
    bus.in_data = mk(16'h8113, 21);
    for (int c = 0; c < 5; c++) begin
      #1 chk($sformatf("bp%0d in_ready", c), 64'(bus.in_ready), 64'(0));
      @(posedge rc_clk); #1;
      check_outs($sformatf("bp%0d hold", c), 3'b010, 16'h0, 16'h0010, 16'h0, 20, 16'd3);
      @(negedge rc_clk);
    end
    bus.out_ready = 3'b111;
    #1 chk("bp release in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge rc_clk); #1;
    check_outs("bp release", 3'b111, 16'h8100, 16'h0010, 16'h0003, 21, 16'd3);

    // More drops: wide counter keeps counting, narrow one saturates at 7.
    for (int j = 1; j <= 5; j++) begin
      @(negedge rc_clk);
      bus.in_valid = 1'b1;
      bus.in_data  = mk(16'h00E0, 30 + j);
      @(posedge rc_clk); #1;
      chk($sformatf("drop%0d valid", j), 64'(bus.out_valid), 64'(0));
      chk($sformatf("drop%0d cnt", j), 64'(drop_cnt), 64'(3 + j));
      chk($sformatf("drop%0d sat", j), 64'(sat_cnt), 64'((3 + j > 7) ? 7 : 3 + j));
    end

    // Reset while port 0 is stalled.
    @(negedge rc_clk);
    bus.out_ready = 3'b110;
    bus.in_data   = mk(16'h0100, 40);
    @(posedge rc_clk); #1;
    check_outs("stall load", 3'b001, 16'h0100, 16'h0, 16'h0, 40, 16'd8);
    @(negedge rc_clk);
    rst         = 1'b1;
    bus.in_data = mk(16'h0001, 41);
    #1 chk("mid rst in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge rc_clk); #1;
    chk("mid rst valid", 64'(bus.out_valid), 64'(0));
    chk("mid rst drop", 64'(drop_cnt), 64'(0));
    chk("mid rst sat", 64'(sat_cnt), 64'(0));
    @(negedge rc_clk);
    rst           = 1'b0;
    bus.out_ready = 3'b111;
    #1 chk("post rst in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge rc_clk); #1;
    check_outs("post rst", 3'b100, 16'h0, 16'h0, 16'h0001, 41, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rc_multicast_fork.md
Name: rc_multicast_fork

Overview:
- Parametrised multicast route-compute stage for the router input port.
- Takes one flit per handshake and splits its destination bitmap across NUM_OUT output ports using per-port destination masks.
- Emits one copy per port whose masked sub-bitmap is non-zero. Each copy carries its one-hot direction.
- Every output has its own one-deep buffered valid/ready channel, so slow ports stall the input without losing copies.

Parameters:
- DATASIZE, 30, flit width in bits.
- DST_W, 16, destination bitmap width.
- DST_LSB, 9, LSB position of the destination bitmap in the flit.
- NUM_OUT, 3, number of output ports/copies.
- PORT_MASK, {16'h000F,16'h0010,16'hFF00}, packed NUM_OUT*DST_W. Slice i is the destinations reachable via port i.
- PORT_DIR, {5'b00010,5'b00001,5'b00100}, packed NUM_OUT*5. Slice i is the one-hot direction for port i.
- CNT_W, 16, width of the drop counter.

Ports:
- rc_clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATASIZE  incoming flit.
- in_valid  in  1  flit present.
- in_ready  out  1  fork can accept this cycle.
- out_data  out  NUM_OUT*DATASIZE  per-port flit copies, packed with port 0 at LSBs.
- out_dir  out  NUM_OUT*5  per-port one-hot direction.
- out_valid  out  NUM_OUT  per-port copy valid.
- out_ready  in  NUM_OUT  per-port downstream ready.
- drop_cnt  out  CNT_W  saturating count of flits matching no port.

Behaviour:
- Reset, synchronous, rst=1 at rc_clk edge:
  - out_valid=0, out_dir=0, out_data=0, drop_cnt=0.
  - in_ready is forced 0 while rst=1.
- Definitions:
  - dst = in_data[DST_LSB +: DST_W].
  - sub_i = dst & PORT_MASK[i].
  - need_i = |sub_i.
  - free_i = ~out_valid[i] | out_ready[i].
- in_ready (combinational) = ~rst & (&free). The input is accepted only when every slot is empty or draining this cycle, so all copies of a flit are loaded atomically in the same cycle.
- Accept = in_valid & in_ready. On accept, for each i with need_i:
  - out_data[i] is loaded with in_data, with the dst field replaced by sub_i and bit 0 forced to 1.
  - out_dir[i] = PORT_DIR[i].
  - out_valid[i] = 1.
- Slots with ~need_i on accept: if draining, they go empty (out_valid=0, out_dir=0). out_data holds its last value.
- Latency: one rc_clk from accept to out_valid.
- Full throughput: one flit per cycle while all needed ports are ready.
- Slot hold: while out_valid[i] & ~out_ready[i], out_data[i] and out_dir[i] are stable.
- Slot drain: out_valid[i] & out_ready[i] with no new accept → out_valid[i]=0 and out_dir[i]=0 next cycle.
- Simultaneous drain and accept into the same slot: the slot reloads with no bubble.
- Zero match (accept with need=0): no slot is loaded and drop_cnt increments, saturating at all-ones.
- Overlapping masks are legal; the same destination bit may then appear in several copies.
- in_valid with in_ready=0: nothing happens. The upstream holds its data (standard valid/ready).
- Reset mid-operation discards all pending copies. The first accept is possible the cycle after rst deasserts.
- No combinational path from in_valid to out_*. in_ready depends only on out_valid (registered) and out_ready.

Decomposition:
- Package rc_mc_pkg holds:
  - Direction constants DIR_L=5'b00001, DIR_S=5'b00010, DIR_E=5'b00100, DIR_W=5'b01000, DIR_N=5'b10000.
  - The flit field positions DST_LSB/DST_W.
  - A helper function that rewrites the dst field.
- Sub-module rc_mc_out_slot: a one-deep valid/ready register holding data+dir, instantiated NUM_OUT times by generate. The top holds the masking, in_ready and drop counter.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → in_ready=0; all out_* = 0; drop_cnt=0.
- Full split with defaults: dst=16'h8113, all out_ready=1 → next cycle:
  - port0 dst=16'h8100, dir=00100;
  - port1 dst=16'h0010, dir=00001;
  - port2 dst=16'h0003, dir=00010;
  - all bit0=1, other fields equal to in_data.
- Partial split and back-to-back: dst=16'h0002, then dst=16'h0200 on consecutive cycles.
  - Cycle 1: only port2 valid.
  - Cycle 2: port2 valid drops and port0 becomes valid. No bubble.
- Backpressure: out_ready[1]=0 with port1 holding a copy → in_ready=0 and port1 data stable for 5 cycles. Raising out_ready[1] accepts the waiting flit the same cycle.
- Drop: send dst=16'h00E0 three times → no out_valid; drop_cnt=3. Preload near all-ones → saturates at 16'hFFFF.
- Reset mid-stall: assert rst while port0 is stalled → out_valid=0 next cycle; the next flit is accepted normally after release.
